// File: rtl/uart_pkg.sv
// Shared types and widths for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the final cycle of each serial bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam logic [UART_CNT_W-1:0] CntMax = UART_CNT_W'(CLKS_PER_BIT - 1);

  logic [UART_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = (cnt_q == CntMax);
    cnt_d   = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a registered-read FIFO and sends one frame per byte.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [UART_DATA_W-1:0] fifo_data,
  output logic                   fifo_rd_en,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  uart_tx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   parity_q, parity_d;
  logic                   bit_end;
  logic                   pop_ok;
  logic                   cnt_clear;

  assign pop_ok = enable & ~fifo_empty;
  // Counter restarts on every state change and is held at zero while idle.
  assign cnt_clear = (state_d != state_q) || (state_q == IDLE);
  assign busy = (state_q != IDLE) | fifo_rd_en;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    parity_d   = parity_q;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    tx         = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pop_ok) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        shreg_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx = shreg_q[0];
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[UART_DATA_W-1:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        tx = parity_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // bit_idx_q doubles as the stop-bit index here.
        if (bit_end) begin
          if (bit_idx_q == LastStop) begin
            frame_done = 1'b1;
            bit_idx_d  = '0;
            if (pop_ok) begin
              fifo_rd_en = 1'b1;
              state_d    = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: dut_a is 8N1, dut_b is even parity with two stop bits; each has a FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       enable_a, enable_b;
  logic       fifo_empty_a, fifo_empty_b;
  logic [7:0] fifo_data_a = 8'h00;
  logic [7:0] fifo_data_b = 8'h00;
  logic       rd_en_a, tx_a, busy_a, done_a;
  logic       rd_en_b, tx_b, busy_b, done_b;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  int wr_a = 0, rd_a = 0, pops_a = 0, under_a = 0;
  int wr_b = 0, rd_b = 0, pops_b = 0, under_b = 0;

  int vectors = 0;
  int errors  = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1), .PARITY_EN(0)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable_a),
    .fifo_empty(fifo_empty_a),
    .fifo_data (fifo_data_a),
    .fifo_rd_en(rd_en_a),
    .tx        (tx_a),
    .busy      (busy_a),
    .frame_done(done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2), .PARITY_EN(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable_b),
    .fifo_empty(fifo_empty_b),
    .fifo_data (fifo_data_b),
    .fifo_rd_en(rd_en_b),
    .tx        (tx_b),
    .busy      (busy_b),
    .frame_done(done_b)
  );

  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_empty_b = (wr_b == rd_b);

  // Registered-read FIFO models; a pop while empty is recorded as an underflow.
  always @(posedge clk) begin
    if (rd_en_a) begin
      pops_a <= pops_a + 1;
      if (wr_a == rd_a) under_a <= under_a + 1;
      else begin
        fifo_data_a <= mem_a[rd_a % 16];
        rd_a        <= rd_a + 1;
      end
    end
    if (rd_en_b) begin
      pops_b <= pops_b + 1;
      if (wr_b == rd_b) under_b <= under_b + 1;
      else begin
        fifo_data_b <= mem_b[rd_b % 16];
        rd_b        <= rd_b + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    mem_a[wr_a % 16] = d;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [7:0] d);
    mem_b[wr_b % 16] = d;
    wr_b = wr_b + 1;
  endtask

  // Serial bit sequence, LSB first: start, data, optional parity, then stop bits (all ones).
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit par);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par) f[9] = ^d;
    return f;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;
    #2;
    vectors++;
    if ({tx_a, busy_a, rd_en_a, done_a, tx_b, busy_b} !== 6'b100010) begin
      errors++;
      $display("FAIL reset_state: got %b want 100010",
               {tx_a, busy_a, rd_en_a, done_a, tx_b, busy_b});
    end
    repeat (3) tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      vectors++;
      if ({tx_a, busy_a, rd_en_a, tx_b, busy_b, rd_en_b} !== 6'b100100) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b want 100100", i,
                 {tx_a, busy_a, rd_en_a, tx_b, busy_b, rd_en_b});
      end
    end
  endtask

  task automatic test_single();
    int p0;
    logic [11:0] exp;
    logic [3:0]  want;
    p0  = pops_a;
    exp = frame_bits(8'hA5, 1'b0);
    push_a(8'hA5);
    #1;
    vectors++;
    if ({rd_en_a, busy_a, tx_a} !== 3'b111) begin
      errors++;
      $display("FAIL single_pop: got %b want 111", {rd_en_a, busy_a, tx_a});
    end
    tick();
    vectors++;
    if ({rd_en_a, busy_a, tx_a, done_a} !== 4'b0110) begin
      errors++;
      $display("FAIL single_fetch: got %b want 0110", {rd_en_a, busy_a, tx_a, done_a});
    end
    for (int i = 0; i < 160; i++) begin
      tick();
      want = {exp[i/16], (i == 159), 1'b0, 1'b1};
      vectors++;
      if ({tx_a, done_a, rd_en_a, busy_a} !== want) begin
        errors++;
        $display("FAIL single_frame cycle %0d: got %b want %b", i,
                 {tx_a, done_a, rd_en_a, busy_a}, want);
      end
    end
    tick();
    vectors++;
    if ({tx_a, busy_a, done_a, rd_en_a} !== 4'b1000 || pops_a - p0 != 1) begin
      errors++;
      $display("FAIL single_end: got %b pops %0d want 1000 pops 1",
               {tx_a, busy_a, done_a, rd_en_a}, pops_a - p0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [2];
    logic [11:0] exp;
    logic [3:0]  want;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    push_a(bytes[0]);
    push_a(bytes[1]);
    #1;
    vectors++;
    if (rd_en_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pop: got %b want 1", rd_en_a);
    end
    for (int f = 0; f < 2; f++) begin
      tick();
      vectors++;
      if ({rd_en_a, busy_a, tx_a, done_a} !== 4'b0110) begin
        errors++;
        $display("FAIL b2b_fetch %0d: got %b want 0110", f, {rd_en_a, busy_a, tx_a, done_a});
      end
      exp = frame_bits(bytes[f], 1'b0);
      for (int i = 0; i < 160; i++) begin
        tick();
        want = {exp[i/16], (i == 159), (i == 159) && (f == 0), 1'b1};
        vectors++;
        if ({tx_a, done_a, rd_en_a, busy_a} !== want) begin
          errors++;
          $display("FAIL b2b_frame %0d cycle %0d: got %b want %b", f, i,
                   {tx_a, done_a, rd_en_a, busy_a}, want);
        end
      end
    end
    tick();
    vectors++;
    if ({tx_a, busy_a, rd_en_a} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_end: got %b want 100", {tx_a, busy_a, rd_en_a});
    end
  endtask

  task automatic test_parity();
    logic [11:0] exp;
    logic [3:0]  want;
    exp = frame_bits(8'h07, 1'b1);
    push_b(8'h07);
    #1;
    vectors++;
    if ({rd_en_b, busy_b, tx_b} !== 3'b111) begin
      errors++;
      $display("FAIL parity_pop: got %b want 111", {rd_en_b, busy_b, tx_b});
    end
    tick();
    for (int i = 0; i < 192; i++) begin
      tick();
      want = {exp[i/16], (i == 191), 1'b0, 1'b1};
      vectors++;
      if ({tx_b, done_b, rd_en_b, busy_b} !== want) begin
        errors++;
        $display("FAIL parity_frame cycle %0d: got %b want %b", i,
                 {tx_b, done_b, rd_en_b, busy_b}, want);
      end
    end
    tick();
    vectors++;
    if ({tx_b, busy_b, done_b} !== 3'b100) begin
      errors++;
      $display("FAIL parity_end: got %b want 100", {tx_b, busy_b, done_b});
    end
  endtask

  task automatic test_enable_drop();
    logic [11:0] exp;
    logic [3:0]  want;
    exp = frame_bits(8'h3C, 1'b0);
    push_a(8'h3C);
    push_a(8'h11);
    push_a(8'h22);
    #1;
    tick();
    for (int i = 0; i < 160; i++) begin
      tick();
      want = {exp[i/16], (i == 159), 1'b0, 1'b1};
      vectors++;
      if ({tx_a, done_a, rd_en_a, busy_a} !== want) begin
        errors++;
        $display("FAIL endrop_frame cycle %0d: got %b want %b", i,
                 {tx_a, done_a, rd_en_a, busy_a}, want);
      end
      if (i == 48) enable_a = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({tx_a, busy_a, rd_en_a} !== 3'b100) begin
        errors++;
        $display("FAIL endrop_hold cycle %0d: got %b want 100", i, {tx_a, busy_a, rd_en_a});
      end
    end
    enable_a = 1'b1;
    #1;
    vectors++;
    if (rd_en_a !== 1'b1) begin
      errors++;
      $display("FAIL endrop_repop: got %b want 1", rd_en_a);
    end
    tick();
    exp = frame_bits(8'h11, 1'b0);
    for (int i = 0; i < 160; i++) begin
      tick();
      want = {exp[i/16], (i == 159), (i == 159), 1'b1};
      vectors++;
      if ({tx_a, done_a, rd_en_a, busy_a} !== want) begin
        errors++;
        $display("FAIL endrop_frame2 cycle %0d: got %b want %b", i,
                 {tx_a, done_a, rd_en_a, busy_a}, want);
      end
    end
  endtask

  // Continues from test_enable_drop: byte 0x22 has just been popped.
  task automatic test_async_reset();
    int p0;
    logic [11:0] exp;
    logic [3:0]  want;
    tick();
    exp = frame_bits(8'h22, 1'b0);
    for (int i = 0; i <= 84; i++) begin
      tick();
      vectors++;
      if (tx_a !== exp[i/16]) begin
        errors++;
        $display("FAIL abort_frame cycle %0d: got %b want %b", i, tx_a, exp[i/16]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({tx_a, busy_a, rd_en_a, done_a} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset: got %b want 1000", {tx_a, busy_a, rd_en_a, done_a});
    end
    repeat (3) tick();
    reset = 1'b1;
    p0 = pops_a;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({tx_a, busy_a, rd_en_a} !== 3'b100) begin
        errors++;
        $display("FAIL post_reset cycle %0d: got %b want 100", i, {tx_a, busy_a, rd_en_a});
      end
    end
    vectors++;
    if (pops_a != p0) begin
      errors++;
      $display("FAIL post_reset_pops: got %0d want %0d", pops_a, p0);
    end
    exp = frame_bits(8'h5A, 1'b0);
    push_a(8'h5A);
    #1;
    vectors++;
    if (rd_en_a !== 1'b1) begin
      errors++;
      $display("FAIL fresh_pop: got %b want 1", rd_en_a);
    end
    tick();
    for (int i = 0; i < 160; i++) begin
      tick();
      want = {exp[i/16], (i == 159), 1'b0, 1'b1};
      vectors++;
      if ({tx_a, done_a, rd_en_a, busy_a} !== want) begin
        errors++;
        $display("FAIL fresh_frame cycle %0d: got %b want %b", i,
                 {tx_a, done_a, rd_en_a, busy_a}, want);
      end
    end
    tick();
    vectors++;
    if ({tx_a, busy_a} !== 2'b10) begin
      errors++;
      $display("FAIL fresh_end: got %b want 10", {tx_a, busy_a});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_enable_drop();
    test_async_reset();
    vectors++;
    if (under_a != 0 || under_b != 0) begin
      errors++;
      $display("FAIL underflow: got %0d/%0d want 0/0", under_a, under_b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
